// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the FIFO read-side drain controller.
package fifo_pkg;

   localparam int unsigned BW_DEF     = 4;
   localparam int unsigned SIMD_DEF   = 1;
   localparam int unsigned CNT_W_DEF  = 7;
   localparam int unsigned SKID_CNT_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry in-order register buffer; isolates consumer backpressure from the FIFO pop.
module fifo_skid2
   import fifo_pkg::*;
#(
   parameter int unsigned bw   = BW_DEF,
   parameter int unsigned simd = SIMD_DEF
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [bw*simd-1:0]       din,
   input  logic                     pop,
   output logic [bw*simd-1:0]       dout,
   output logic [SKID_CNT_W-1:0]    count
);

   localparam int unsigned DW = bw * simd;

   logic [DW-1:0]         head_q, head_d;
   logic [DW-1:0]         tail_q, tail_d;
   logic [SKID_CNT_W-1:0] count_q, count_d;
   logic                  pop_ok;
   logic                  push_ok;

   // Next entry contents: head is always the oldest word, tail the second oldest.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      pop_ok  = pop && (count_q != SKID_CNT_W'(0));
      push_ok = push && ((count_q != SKID_CNT_W'(2)) || pop_ok);
      case ({push_ok, pop_ok})
         2'b10: begin
            if (count_q == SKID_CNT_W'(0)) head_d = din;
            else                           tail_d = din;
            count_d = count_q + SKID_CNT_W'(1);
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - SKID_CNT_W'(1);
         end
         2'b11: begin
            if (count_q == SKID_CNT_W'(1)) begin
               head_d = din;
            end else begin
               head_d = tail_q;
               tail_d = din;
            end
         end
         default: ;
      endcase
   end

   // Entry and occupancy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign dout  = head_q;
   assign count = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a fixed-length burst from the dual-clock FIFO and streams it out as valid/ready.
module fifo_burst_reader
   import fifo_pkg::*;
#(
   parameter int unsigned bw    = BW_DEF,
   parameter int unsigned simd  = SIMD_DEF,
   parameter int unsigned cnt_w = CNT_W_DEF
)(
   input  logic                 rd_clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [cnt_w-1:0]     burst_len,
   input  logic [bw*simd-1:0]   fifo_out,
   input  logic                 fifo_empty,
   output logic                 fifo_rd,
   output logic [bw*simd-1:0]   o_data,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic                 busy,
   output logic                 done,
   output logic [cnt_w-1:0]     words_left
);

   state_t                state_q, state_d;
   logic [cnt_w-1:0]      words_left_q, words_left_d;
   logic [SKID_CNT_W-1:0] buf_count;
   logic                  pop_c;

   // Burst sequencing; the pop strobe depends only on state, counter, FIFO flag and buffer room.
   always_comb begin
      state_d      = state_q;
      words_left_d = words_left_q;
      pop_c        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (burst_len != '0) begin
                  state_d      = RUN;
                  words_left_d = burst_len;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            pop_c = (words_left_q != '0) && !fifo_empty && (buf_count < SKID_CNT_W'(2));
            if (pop_c) begin
               words_left_d = words_left_q - cnt_w'(1);
               if (words_left_q == cnt_w'(1)) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (buf_count == SKID_CNT_W'(0)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and remaining-word counter.
   always_ff @(posedge rd_clk) begin
      if (reset) begin
         state_q      <= IDLE;
         words_left_q <= '0;
      end else begin
         state_q      <= state_d;
         words_left_q <= words_left_d;
      end
   end

   fifo_skid2 #(
      .bw   (bw),
      .simd (simd)
   ) u_skid (
      .clk   (rd_clk),
      .reset (reset),
      .push  (pop_c),
      .din   (fifo_out),
      .pop   (o_valid && o_ready),
      .dout  (o_data),
      .count (buf_count)
   );

   assign fifo_rd    = pop_c;
   assign o_valid    = (buf_count != SKID_CNT_W'(0));
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign words_left = words_left_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench: behavioural FIFO, word-stream reference model and a decoupled output monitor.
module tb_fifo_burst_reader;

   localparam int unsigned BW    = 4;
   localparam int unsigned SIMD  = 1;
   localparam int unsigned CNT_W = 7;
   localparam int unsigned DW    = BW * SIMD;

   logic              rd_clk = 1'b0;
   logic              reset;
   logic              start;
   logic [CNT_W-1:0]  burst_len;
   logic [DW-1:0]     fifo_out;
   logic              fifo_empty;
   logic              fifo_rd;
   logic [DW-1:0]     o_data;
   logic              o_valid;
   logic              o_ready;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  words_left;

   // Behavioural 64-deep FIFO: writer owns wr_total, the pop process owns rd_total.
   logic [DW-1:0] mem [64];
   int            wr_total = 0;
   int            rd_total = 0;

   // Reference model: every word ever written, and the stream indices each burst must deliver.
   logic [DW-1:0] stream [$];
   int            exp_q  [$];
   int            model_rd = 0;

   int vectors    = 0;
   int miscompares = 0;

   assign fifo_empty = (wr_total == rd_total);
   assign fifo_out   = mem[rd_total[5:0]];

   always #5 rd_clk = ~rd_clk;

   always @(posedge rd_clk) begin
      if (fifo_rd && !fifo_empty) rd_total <= rd_total + 1;
   end

   fifo_burst_reader #(
      .bw    (BW),
      .simd  (SIMD),
      .cnt_w (CNT_W)
   ) dut (
      .rd_clk     (rd_clk),
      .reset      (reset),
      .start      (start),
      .burst_len  (burst_len),
      .fifo_out   (fifo_out),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_ready    (o_ready),
      .busy       (busy),
      .done       (done),
      .words_left (words_left)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic fifo_write(input logic [DW-1:0] v);
      mem[wr_total[5:0]] = v;
      stream.push_back(v);
      wr_total++;
   endtask

   // Issue a burst; the model expects the next len words of the written stream.
   task automatic issue_start(input int len);
      for (int i = 0; i < len; i++) exp_q.push_back(model_rd + i);
      model_rd += len;
      start     = 1'b1;
      burst_len = CNT_W'(len);
      @(posedge rd_clk); #2;
      start     = 1'b0;
   endtask

   // Called at the negedge where done is seen: checks pulse width, busy drop and totals.
   task automatic post_done(input string tag);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
      @(negedge rd_clk);
      check({tag, "_done_single"}, 32'(done), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_pop_total"}, 32'(rd_total), 32'(model_rd));
      @(posedge rd_clk); #2;
   endtask

   task automatic wait_done(input string tag, input int budget, output int n);
      n = 0;
      forever begin
         @(negedge rd_clk);
         n++;
         if (done || n >= budget) break;
      end
      post_done(tag);
   endtask

   // Monitor: pops the scoreboard on every accepted transfer, checks hold stability.
   initial begin
      logic [DW-1:0] prev_data;
      logic          prev_hold;
      int            idx;
      prev_hold = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge rd_clk);
         if (reset) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) check("hold_stable", 32'(o_data), 32'(prev_data));
            if (fifo_rd) check("rd_while_empty", 32'(fifo_empty), 32'd0);
            if (o_valid && o_ready) begin
               check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  idx = exp_q.pop_front();
                  check("o_data", 32'(o_data), 32'(stream[idx]));
               end
            end
            prev_hold = o_valid && !o_ready;
            prev_data = o_data;
         end
      end
   end

   initial begin
      int n;
      int base;
      int len;
      int pre;
      int written;

      // Reset held two cycles with start asserted.
      reset     = 1'b1;
      start     = 1'b1;
      burst_len = CNT_W'(5);
      o_ready   = 1'b1;
      for (int i = 1; i <= 4; i++) fifo_write(DW'(i));
      for (int c = 0; c < 2; c++) begin
         @(negedge rd_clk);
         check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
         check("rst_o_valid", 32'(o_valid), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_done", 32'(done), 32'd0);
         check("rst_words_left", 32'(words_left), 32'd0);
         check("rst_o_data", 32'(o_data), 32'd0);
      end
      @(posedge rd_clk); #2;
      reset = 1'b0;
      start = 1'b0;
      check("rst_no_pops", 32'(rd_total), 32'd0);

      // Nominal 4-word burst with o_ready high.
      issue_start(4);
      for (int i = 0; i < 4; i++) begin
         @(negedge rd_clk);
         check("nom_rd_high", 32'(fifo_rd), 32'd1);
      end
      @(negedge rd_clk);
      check("nom_rd_low", 32'(fifo_rd), 32'd0);
      wait_done("nom", 40, n);

      // Backpressure: consumer stalled, only two pops, head held.
      o_ready = 1'b0;
      base = model_rd;
      for (int i = 0; i < 8; i++) fifo_write(DW'($urandom_range(0, 15)));
      issue_start(8);
      repeat (8) @(negedge rd_clk);
      check("bp_two_pops", 32'(rd_total - base), 32'd2);
      check("bp_rd_low", 32'(fifo_rd), 32'd0);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_head", 32'(o_data), 32'(stream[base]));
      check("bp_words_left", 32'(words_left), 32'd6);
      @(posedge rd_clk); #2;
      o_ready = 1'b1;
      wait_done("bp", 60, n);

      // Empty stall: two words available, three more arrive later.
      for (int i = 0; i < 2; i++) fifo_write(DW'($urandom_range(0, 15)));
      issue_start(5);
      repeat (10) @(negedge rd_clk);
      check("stall_rd_low", 32'(fifo_rd), 32'd0);
      check("stall_valid_low", 32'(o_valid), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_words_left", 32'(words_left), 32'd3);
      @(posedge rd_clk); #2;
      for (int i = 0; i < 3; i++) fifo_write(DW'($urandom_range(0, 15)));
      wait_done("stall", 40, n);

      // Zero-length burst: straight to done, no pops.
      issue_start(0);
      wait_done("zero", 10, n);
      check("zero_latency", 32'(n), 32'd1);

      // Maximum burst across the FIFO pointer wrap.
      for (int i = 0; i < 64; i++) fifo_write(DW'(i % 16));
      issue_start(64);
      wait_done("max", 300, n);
      check("max_fifo_empty", 32'(fifo_empty), 32'd1);

      // Abort: reset after two pops clears everything; popped words are lost.
      o_ready = 1'b0;
      base = model_rd;
      for (int i = 0; i < 6; i++) fifo_write(DW'($urandom_range(0, 15)));
      issue_start(6);
      repeat (6) @(negedge rd_clk);
      check("abort_two_pops", 32'(rd_total - base), 32'd2);
      @(posedge rd_clk); #2;
      reset = 1'b1;
      @(posedge rd_clk);
      @(negedge rd_clk);
      check("abort_fifo_rd", 32'(fifo_rd), 32'd0);
      check("abort_o_valid", 32'(o_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_words_left", 32'(words_left), 32'd0);
      @(posedge rd_clk); #2;
      reset = 1'b0;
      exp_q.delete();
      model_rd = base + 2;
      check("abort_pop_total", 32'(rd_total), 32'(model_rd));
      o_ready = 1'b1;

      // Start during RUN is ignored; only the original 4 words are popped.
      for (int i = 0; i < 9; i++) fifo_write(DW'($urandom_range(0, 15)));
      issue_start(4);
      start     = 1'b1;
      burst_len = CNT_W'(9);
      @(posedge rd_clk); #2;
      start     = 1'b0;
      wait_done("ign", 40, n);
      issue_start(9);
      wait_done("drain", 60, n);

      // Randomised bursts with random backpressure and trickling FIFO writes.
      for (int b = 0; b < 6; b++) begin
         len = int'($urandom_range(1, 24));
         pre = int'($urandom_range(0, len));
         for (int i = 0; i < pre; i++) fifo_write(DW'($urandom_range(0, 15)));
         written = pre;
         issue_start(len);
         n = 0;
         while (n < 400) begin
            @(negedge rd_clk);
            if (done) break;
            @(posedge rd_clk); #2;
            n++;
            o_ready = ($urandom_range(0, 3) != 0);
            if (written < len && $urandom_range(0, 2) == 0) begin
               fifo_write(DW'($urandom_range(0, 15)));
               written++;
            end
         end
         post_done("rand");
         o_ready = 1'b1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
